// File: rtl/med_ctrl.sv
// -----------------------------------------------------------------------------
// med_ctrl
// Control sequencer for the 9-tap median datapath (a ring of compare/exchange
// registers).
//
// The block accepts a frame of DATA_QTDE samples marked by DSI. It then steps
// the datapath through several passes:
//   - compare passes, with ROT cycles between them;
//   - a FINAL sweep;
//   - a single DONE cycle, where DSO flags that the datapath DO holds the median.
// The block carries no data itself.
//
// Ports
//   CLK      in   clock, rising edge
//   RST      in   synchronous reset, active-high
//   DSI      in   upstream sample valid
//   MED_DSI  out  datapath select: 1 loads DI into R[0], 0 feeds MIN
//   MED_BYP  out  datapath bypass: 1 shifts R[N-2] into R[N-1], 0 loads MAX
//   DSO      out  median valid on datapath DO this cycle
//   ERR      out  (only with MED_CTRL_ERR_EN) sticky DSI-gap-in-load error
//   BUSY     out  frame being processed; DSI ignored while high
//
// Build option
//   MED_CTRL_ERR_EN
//     Defined:   a DSI gap during LOAD aborts the frame and sets ERR.
//     Undefined: a DSI gap during LOAD simply stalls the load.
// -----------------------------------------------------------------------------
module med_ctrl #(
    parameter int DATA_QTDE  = 9,
    parameter int CNT_WIDTH  = 4,
    parameter int PASS_WIDTH = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic DSI,
    output logic MED_DSI,
    output logic MED_BYP,
    output logic DSO,
`ifdef MED_CTRL_ERR_EN
    output logic ERR,
`endif
    output logic BUSY
);

    localparam int P = (DATA_QTDE - 1) / 2;

    localparam logic [CNT_WIDTH-1:0]  LOAD_LAST  = CNT_WIDTH'(DATA_QTDE - 1);
    localparam logic [CNT_WIDTH-1:0]  CMP_LAST   = CNT_WIDTH'(DATA_QTDE - 2);
    localparam logic [CNT_WIDTH-1:0]  FINAL_LAST = CNT_WIDTH'(P - 1);
    localparam logic [PASS_WIDTH-1:0] PASS_LAST  = PASS_WIDTH'(P - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CMP,
        ROT,
        FINAL,
        DONE
    } state_t;

    state_t                state, state_n;
    logic [CNT_WIDTH-1:0]  cnt, cnt_n;
    logic [PASS_WIDTH-1:0] pass, pass_n;
    logic [CNT_WIDTH-1:0]  cmp_last;

`ifdef MED_CTRL_ERR_EN
    logic err, err_n;
    assign ERR = err;
`endif

    // The last compare pass runs one extra cycle.
    // This lets the final exchange settle before the FINAL sweep starts.
    assign cmp_last = (pass == PASS_LAST) ? LOAD_LAST : CMP_LAST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            pass  <= '0;
`ifdef MED_CTRL_ERR_EN
            err   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pass  <= pass_n;
`ifdef MED_CTRL_ERR_EN
            err   <= err_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pass_n  = pass;
`ifdef MED_CTRL_ERR_EN
        err_n   = err;
`endif
        MED_DSI = 1'b0;
        MED_BYP = 1'b1;
        BUSY    = 1'b0;
        DSO     = 1'b0;

        unique case (state)
            IDLE: begin
                MED_DSI = DSI;
                if (DSI) begin
                    state_n = LOAD;
                    cnt_n   = CNT_WIDTH'(1);
                    pass_n  = '0;
`ifdef MED_CTRL_ERR_EN
                    err_n   = 1'b0;
`endif
                end
            end

            LOAD: begin
                MED_DSI = DSI;
                if (cnt > LOAD_LAST) begin
                    // Out-of-range count: treat as illegal state.
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (DSI) begin
                    if (cnt == LOAD_LAST) begin
                        state_n = CMP;
                        cnt_n   = '0;
                        pass_n  = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
`ifdef MED_CTRL_ERR_EN
                    // A gap aborts the partial frame.
                    err_n   = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
`endif
                end
            end

            CMP: begin
                MED_BYP = 1'b0;
                BUSY    = 1'b1;
                if (pass > PASS_LAST || cnt > cmp_last) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    pass_n  = '0;
                end else if (cnt == cmp_last) begin
                    cnt_n   = '0;
                    state_n = (pass == PASS_LAST) ? FINAL : ROT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ROT: begin
                BUSY = 1'b1;
                if (pass >= PASS_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    pass_n  = '0;
                end else begin
                    pass_n  = pass + 1'b1;
                    cnt_n   = '0;
                    state_n = CMP;
                end
            end

            FINAL: begin
                MED_BYP = 1'b0;
                BUSY    = 1'b1;
                if (cnt > FINAL_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    pass_n  = '0;
                end else if (cnt == FINAL_LAST) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            DONE: begin
                DSO     = 1'b1;
                MED_DSI = DSI;
                // A sample here starts the next frame, so no cycle is lost.
                if (DSI) begin
                    state_n = LOAD;
                    cnt_n   = CNT_WIDTH'(1);
                    pass_n  = '0;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    pass_n  = '0;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                pass_n  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_med_ctrl.sv
// -----------------------------------------------------------------------------
// tb_med_ctrl
// Scoreboard bench for med_ctrl.
//
// Each stimulus cycle pushes the hand-derived expected control outputs into a
// queue. A monitor on the falling edge pops one entry and compares it against
// the DUT outputs for that cycle.
//
// Frame phase k counts cycles from the first sample of a gap-free frame:
//   - phases 0..8:   load;
//   - phases 9..48:  busy, with ROT (bypass high) at phases 17, 26 and 35;
//   - phase 49:      DSO.
// -----------------------------------------------------------------------------
module tb_med_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic DSI;
    logic MED_DSI;
    logic MED_BYP;
    logic DSO;
    logic BUSY;
`ifdef MED_CTRL_ERR_EN
    logic ERR;
`endif

    typedef struct packed {
        logic chk;
        logic dso;
        logic busy;
        logic byp;
        logic mdsi;
        logic err;
    } exp_t;

    exp_t sb[$];
    int   vecCount    = 0;
    int   missCount   = 0;
    int   dsoSeen     = 0;
    int   dsoExpected = 0;
    logic errExp      = 1'b0;

    med_ctrl dut (
        .CLK     (CLK),
        .RST     (RST),
        .DSI     (DSI),
        .MED_DSI (MED_DSI),
        .MED_BYP (MED_BYP),
        .DSO     (DSO),
`ifdef MED_CTRL_ERR_EN
        .ERR     (ERR),
`endif
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    // Compare one scoreboard entry against the outputs of the current cycle.
    task automatic checkOutput();
        exp_t e;
        logic errAct;
        e = sb.pop_front();
`ifdef MED_CTRL_ERR_EN
        errAct = ERR;
`else
        errAct = 1'b0;
`endif
        if (DSO === 1'b1) dsoSeen++;
        if (e.chk) begin
            vecCount++;
            if ({DSO, BUSY, MED_BYP, MED_DSI, errAct} !==
                {e.dso, e.busy, e.byp, e.mdsi, e.err}) begin
                missCount++;
                $display("[TB] FAIL ctrl t=%0t dso/busy/byp/mdsi/err got %b%b%b%b%b want %b%b%b%b%b",
                         $time, DSO, BUSY, MED_BYP, MED_DSI, errAct,
                         e.dso, e.busy, e.byp, e.mdsi, e.err);
            end
        end
    endtask

    // Monitor: pop and compare once per cycle, away from the active edge.
    always @(negedge CLK) begin
        if (sb.size() > 0) checkOutput();
    end

    function automatic exp_t idleExp();
        exp_t e;
        e.chk  = 1'b1;
        e.dso  = 1'b0;
        e.busy = 1'b0;
        e.byp  = 1'b1;
        e.mdsi = 1'b0;
        e.err  = errExp;
        return e;
    endfunction

    function automatic exp_t phaseExp(input int k, input logic dsi);
        exp_t e;
        e.chk  = 1'b1;
        e.dso  = 1'b0;
        e.busy = 1'b0;
        e.byp  = 1'b1;
        e.mdsi = dsi;
        e.err  = 1'b0;
        if (k >= 9 && k <= 48) begin
            e.busy = 1'b1;
            e.mdsi = 1'b0;
            e.byp  = (k == 17 || k == 26 || k == 35);
        end else if (k == 49) begin
            e.dso = 1'b1;
        end
        if (k == 0) e.err = errExp;
        return e;
    endfunction

    task automatic applyStimulus(input logic rst, input logic dsi, input exp_t e);
        RST = rst;
        DSI = dsi;
        sb.push_back(e);
        if (e.chk && e.dso) dsoExpected++;
        @(posedge CLK);
        #1;
    endtask

    // Drive frame phases [from, to].
    // DSI is high on phases 0..8, plus phases p1 and p2 (pulses while busy),
    // plus phase 49 when dsiDone is set (the next frame starts in the DSO cycle).
    task automatic driveFrame(input int from, input int to, input int p1,
                              input int p2, input logic dsiDone);
        for (int k = from; k <= to; k++) begin
            logic d;
            d = (k <= 8) || (k == p1) || (k == p2) || (k == 49 && dsiDone);
            applyStimulus(1'b0, d, phaseExp(k, d));
            if (k == 0) errExp = 1'b0;
        end
    endtask

    initial begin
        RST = 1'b1;
        DSI = 1'b0;
        @(posedge CLK);
        #1;

        // Reset held three cycles, then idle.
        applyStimulus(1'b1, 1'b0, idleExp());
        applyStimulus(1'b1, 1'b0, idleExp());
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, idleExp());

        // Nominal frame: DSO at phase 49.
        driveFrame(0, 49, -1, -1, 1'b0);
        applyStimulus(1'b0, 1'b0, idleExp());

        // Back-to-back frames.
        // The second frame's first sample lands in the DSO cycle.
        driveFrame(0, 48, -1, -1, 1'b0);
        driveFrame(49, 49, -1, -1, 1'b1);
        driveFrame(1, 49, -1, -1, 1'b0);
        applyStimulus(1'b0, 1'b0, idleExp());

        // DSI pulses while busy are ignored.
        driveFrame(0, 49, 20, 40, 1'b0);
        applyStimulus(1'b0, 1'b0, idleExp());

        // One DSI gap after sample 4.
        driveFrame(0, 4, -1, -1, 1'b0);
        applyStimulus(1'b0, 1'b0, phaseExp(5, 1'b0));
`ifdef MED_CTRL_ERR_EN
        errExp = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, idleExp());
`else
        driveFrame(5, 49, -1, -1, 1'b0);
        applyStimulus(1'b0, 1'b0, idleExp());
`endif

        // Reset at phase 30, then a fresh frame.
        driveFrame(0, 29, -1, -1, 1'b0);
        applyStimulus(1'b1, 1'b0, phaseExp(30, 1'b0));
        errExp = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, idleExp());
        driveFrame(0, 49, -1, -1, 1'b0);
        applyStimulus(1'b0, 1'b0, idleExp());

        // Let the monitor drain the last entry.
        @(negedge CLK);
        #1;

        vecCount++;
        if (sb.size() != 0) begin
            missCount++;
            $display("[TB] FAIL drain pending entries got %0d want 0", sb.size());
        end

        vecCount++;
        if (dsoSeen != dsoExpected) begin
            missCount++;
            $display("[TB] FAIL dso_count got %0d want %0d", dsoSeen, dsoExpected);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
